// File: rtl/eeprom_cmd_seq_if.sv
// Command/response bundle between the EEPROM burst sequencer and the serial EEPROM controller.
// The bidirectional DATA byte lane stays a plain inout port on the sequencer.
interface eeprom_cmd_seq_if;
    logic        START;
    logic [10:0] BASE_ADDR;
    logic [7:0]  LEN;
    logic        WR;
    logic        RD;
    logic [10:0] ADDR;
    logic        ACK;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [7:0]  ERR_CNT;

    modport master (
        input  START, BASE_ADDR, LEN, ACK,
        output WR, RD, ADDR, BUSY, DONE, ERR, ERR_CNT
    );

    modport slave (
        output START, BASE_ADDR, LEN, ACK,
        input  WR, RD, ADDR, BUSY, DONE, ERR, ERR_CNT
    );
endinterface

// File: rtl/eeprom_cmd_seq.sv
// Writes an address-keyed pattern burst to a serial EEPROM controller, optionally reading it back.
// Define EEPROM_SEQ_VERIFY_EN to enable the readback/compare phase.
module eeprom_cmd_seq #(
    parameter logic [7:0]  SEED    = 8'hA5,
    parameter logic [15:0] WR_GAP  = 16'd200,
    parameter logic [15:0] TIMEOUT = 16'd4000
) (
    input  logic             CLK,
    input  logic             RESET,
    inout  wire  [7:0]       DATA,
    eeprom_cmd_seq_if.master bus
);
    localparam int unsigned AW = 11;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_WAIT = 3'd2,
        S_WR_GAP  = 3'd3,
`ifdef EEPROM_SEQ_VERIFY_EN
        S_RD_REQ  = 3'd4,
        S_RD_WAIT = 3'd5,
        S_CMP     = 3'd6,
`endif
        S_FIN     = 3'd7
    } state_t;

    state_t        state;
    logic [AW-1:0] base_q;
    logic [DW-1:0] len_q;
    logic [DW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          data_oe;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
`ifdef EEPROM_SEQ_VERIFY_EN
    logic          rd_q;
    logic [DW-1:0] err_cnt_q;
    logic [DW-1:0] cap_q;
`endif

    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_pat;
    logic          more;
    logic          gap_done;

    // Address arithmetic wraps naturally at 2048 bytes.
    assign cur_addr = base_q + AW'(idx);
    assign cur_pat  = cur_addr[DW-1:0] ^ SEED;
    assign more     = (9'(idx) + 9'd1) < 9'(len_q);
    assign gap_done = (17'(cnt) + 17'd1) >= 17'(WR_GAP);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            idx       <= '0;
            cnt       <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            data_oe   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef EEPROM_SEQ_VERIFY_EN
            rd_q      <= 1'b0;
            err_cnt_q <= '0;
            cap_q     <= '0;
`endif
        end else begin
            wr_q   <= 1'b0;
            done_q <= 1'b0;
`ifdef EEPROM_SEQ_VERIFY_EN
            rd_q   <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (bus.START) begin
                        base_q <= bus.BASE_ADDR;
                        len_q  <= bus.LEN;
                        idx    <= '0;
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
`ifdef EEPROM_SEQ_VERIFY_EN
                        err_cnt_q <= '0;
`endif
                        state  <= (bus.LEN == 8'd0) ? S_FIN : S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    wr_q    <= 1'b1;
                    addr_q  <= cur_addr;
                    data_q  <= cur_pat;
                    data_oe <= 1'b1;
                    cnt     <= '0;
                    state   <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    // ACK wins over a timeout landing in the same cycle.
                    if (bus.ACK) begin
                        data_oe <= 1'b0;
                        cnt     <= '0;
                        state   <= S_WR_GAP;
                    end else if (cnt == TIMEOUT) begin
                        data_oe <= 1'b0;
                        err_q   <= 1'b1;
                        state   <= S_FIN;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_WR_GAP: begin
                    if (gap_done) begin
                        cnt <= '0;
                        if (more) begin
                            idx   <= idx + 8'd1;
                            state <= S_WR_REQ;
                        end else begin
                            idx   <= '0;
`ifdef EEPROM_SEQ_VERIFY_EN
                            state <= S_RD_REQ;
`else
                            state <= S_FIN;
`endif
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
`ifdef EEPROM_SEQ_VERIFY_EN
                S_RD_REQ: begin
                    rd_q   <= 1'b1;
                    addr_q <= cur_addr;
                    cnt    <= '0;
                    state  <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (bus.ACK) begin
                        cap_q <= DATA;
                        state <= S_CMP;
                    end else if (cnt == TIMEOUT) begin
                        err_q <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_CMP: begin
                    if (cap_q != (addr_q[DW-1:0] ^ SEED)) begin
                        err_q <= 1'b1;
                        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                    end
                    if (more) begin
                        idx   <= idx + 8'd1;
                        state <= S_RD_REQ;
                    end else begin
                        state <= S_FIN;
                    end
                end
`endif
                S_FIN: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign DATA        = data_oe ? data_q : 8'bz;
    assign bus.WR      = wr_q;
    assign bus.ADDR    = addr_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.ERR     = err_q;
`ifdef EEPROM_SEQ_VERIFY_EN
    assign bus.RD      = rd_q;
    assign bus.ERR_CNT = err_cnt_q;
`else
    assign bus.RD      = 1'b0;
    assign bus.ERR_CNT = 8'd0;
`endif
endmodule
